fetch_unit: RTL and testbench

- Instruction fetch front end. Generates PCs, issues word reads to instruction memory, buffers the returned words, and presents them as instruction_type plus PC to the decode/control stage through a valid/ready handshake.
- It is the producer end of the instruction interface that decode consumes.
- It accepts a redirect from the branch resolution logic. On redirect it flushes buffered and in-flight instructions and refetches from the redirect target.

---
 rtl/fetch_unit_pkg.sv | 18 +
 rtl/fetch_unit_if.sv | 35 +++
 rtl/fetch_unit_fifo.sv | 71 +++++++
 rtl/fetch_unit.sv | 84 ++++++++
 tb/tb_fetch_unit.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch types: the instruction word type, the buffered fetch packet and
// the word-alignment helper used by the fetch front end.
package fetch_unit_pkg;

    typedef logic [31:0] instruction_type;

    localparam int unsigned IMEM_WORD_BYTES = 4;

    typedef struct packed {
        instruction_type instruction;
        logic [31:0]     pc;
    } fetch_packet_type;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction memory request/response, branch redirect
// and the instruction stream handed to decode.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [31:0]     imem_req_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            redirect;
    logic [31:0]     redirect_pc;
    logic            out_valid;
    logic            out_ready;
    instruction_type out_instruction;
    logic [31:0]     out_pc;

    // master: the fetch unit; slave: memory, branch unit and decode side
    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect, redirect_pc,
        output out_valid, out_instruction, out_pc,
        input  out_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect, redirect_pc,
        input  out_valid, out_instruction, out_pc,
        output out_ready
    );

endinterface

// File: rtl/fetch_unit_fifo.sv
// Instruction buffer: slots are allocated with their PC when a read is issued and
// marked filled when the in-order response returns; the head is read combinationally.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         alloc,
    input  logic [31:0]                  alloc_pc,
    input  logic                         fill,
    input  instruction_type              fill_data,
    input  logic                         pop,
    output logic                         head_valid,
    output fetch_packet_type             head,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW-1:0]   alloc_ptr;
    logic [PW-1:0]   fill_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [DEPTH-1:0] filled;
    logic [31:0]     pc_mem   [DEPTH];
    instruction_type data_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            rd_ptr    <= '0;
            filled    <= '0;
            occupancy <= '0;
        end else begin
            if (alloc) alloc_ptr <= alloc_ptr + 1'b1;
            if (fill) begin
                fill_ptr         <= fill_ptr + 1'b1;
                filled[fill_ptr] <= 1'b1;
            end
            // a pop always targets a filled slot, so it never collides with the fill slot
            if (pop) begin
                rd_ptr         <= rd_ptr + 1'b1;
                filled[rd_ptr] <= 1'b0;
            end
            case ({fill, pop})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (alloc) pc_mem[alloc_ptr] <= alloc_pc;
        if (fill)  data_mem[fill_ptr] <= fill_data;
    end

    always_comb begin
        head_valid       = filled[rd_ptr];
        head.pc          = '0;
        head.instruction = '0;
        if (head_valid) begin
            head.pc          = pc_mem[rd_ptr];
            head.instruction = data_mem[rd_ptr];
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC generation, credit-limited memory reads,
// in-order response buffering and redirect flush with stale-response dropping.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master fetch_bus
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW+1:0] DEPTH_W = (CW + 2)'(FIFO_DEPTH);

    typedef logic [CW-1:0] count_t;

    logic [31:0]      fetch_pc;
    count_t           outstanding;
    count_t           drop;
    count_t           occupancy;
    logic [CW+1:0]    in_use;
    logic             req_fire;
    logic             rsp_drop;
    logic             rsp_take;
    logic             pop;
    logic             head_valid;
    fetch_packet_type head;

    // drop counts against credit so stale reads never exceed the buffer depth
    assign in_use = {2'b00, occupancy} + {2'b00, outstanding} + {2'b00, drop};

    assign fetch_bus.imem_req_valid = !rst && !fetch_bus.redirect && (in_use < DEPTH_W);
    assign fetch_bus.imem_req_addr  = fetch_pc;

    assign req_fire = fetch_bus.imem_req_valid && fetch_bus.imem_req_ready;
    assign rsp_drop = fetch_bus.imem_rsp_valid && (drop != '0);
    assign rsp_take = fetch_bus.imem_rsp_valid && (drop == '0) && (outstanding != '0);

    assign fetch_bus.out_valid       = head_valid && !fetch_bus.redirect;
    assign fetch_bus.out_pc          = head.pc;
    assign fetch_bus.out_instruction = head.instruction;
    assign pop = fetch_bus.out_valid && fetch_bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else if (fetch_bus.redirect) begin
            fetch_pc    <= align_word(fetch_bus.redirect_pc);
            outstanding <= '0;
            drop        <= drop + outstanding - count_t'(rsp_drop || rsp_take);
        end else begin
            if (req_fire) fetch_pc <= fetch_pc + 32'(IMEM_WORD_BYTES);
            outstanding <= outstanding + count_t'(req_fire) - count_t'(rsp_take);
            drop        <= drop - count_t'(rsp_drop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && fetch_bus.imem_rsp_valid)
            assert (outstanding != '0 || drop != '0)
            else $error("fetch_unit: memory response with no read outstanding");
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (fetch_bus.redirect),
        .alloc      (req_fire),
        .alloc_pc   (fetch_pc),
        .fill       (rsp_take && !fetch_bus.redirect),
        .fill_data  (fetch_bus.imem_rsp_data),
        .pop        (pop),
        .head_valid (head_valid),
        .head       (head),
        .occupancy  (occupancy)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: two instances (RESET_PC 0 and 0xFFFF_FFF8),
// each with an in-order latency memory model and an output monitor.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] due;
    } pend_t;

    logic        clk;
    logic        rst_a;
    logic        rst_b;
    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned lat_a = 1;
    int unsigned rel_a = 0;

    pend_t            pend_a[$];
    pend_t            pend_b[$];
    logic [31:0]      req_log_a[$];
    logic [31:0]      req_log_b[$];
    int unsigned      pop_cyc_a[$];
    fetch_packet_type sb_a[$];
    fetch_packet_type sb_b[$];

    fetch_unit_if bus_a();
    fetch_unit_if bus_b();

    fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut_a (
        .clk       (clk),
        .rst       (rst_a),
        .fetch_bus (bus_a)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(4)) dut_b (
        .clk       (clk),
        .rst       (rst_b),
        .fetch_bus (bus_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return {addr[15:0], ~addr[15:0]};
    endfunction

    function automatic fetch_packet_type make_pkt(input logic [31:0] pc);
        fetch_packet_type p;
        p.pc = pc;
        p.instruction = mem_word(pc);
        return p;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // memory A: fixed latency lat_a, one response per cycle, in order
    initial begin
        bus_a.imem_req_ready = 1'b1;
        bus_a.imem_rsp_valid = 1'b0;
        bus_a.imem_rsp_data  = '0;
        forever begin
            next_cycle();
            if (pend_a.size() != 0 && pend_a[0].due <= cyc) begin
                bus_a.imem_rsp_valid = 1'b1;
                bus_a.imem_rsp_data  = mem_word(pend_a[0].addr);
                void'(pend_a.pop_front());
            end else begin
                bus_a.imem_rsp_valid = 1'b0;
            end
            #7;
            if (rst_a) pend_a.delete();
            else if (bus_a.imem_req_valid && bus_a.imem_req_ready) begin
                pend_a.push_back('{addr: bus_a.imem_req_addr, due: cyc + lat_a});
                req_log_a.push_back(bus_a.imem_req_addr);
            end
        end
    end

    // memory B: latency 1
    initial begin
        bus_b.imem_req_ready = 1'b1;
        bus_b.imem_rsp_valid = 1'b0;
        bus_b.imem_rsp_data  = '0;
        forever begin
            next_cycle();
            if (pend_b.size() != 0 && pend_b[0].due <= cyc) begin
                bus_b.imem_rsp_valid = 1'b1;
                bus_b.imem_rsp_data  = mem_word(pend_b[0].addr);
                void'(pend_b.pop_front());
            end else begin
                bus_b.imem_rsp_valid = 1'b0;
            end
            #7;
            if (rst_b) pend_b.delete();
            else if (bus_b.imem_req_valid && bus_b.imem_req_ready) begin
                pend_b.push_back('{addr: bus_b.imem_req_addr, due: cyc + 1});
                req_log_b.push_back(bus_b.imem_req_addr);
            end
        end
    end

    initial forever begin
        fetch_packet_type e;
        @(posedge clk);
        #8;
        if (bus_a.out_valid && bus_a.out_ready) begin
            pop_cyc_a.push_back(cyc);
            if (sb_a.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL out_a_unexpected actual_pc=%h required=none", bus_a.out_pc);
            end else begin
                e = sb_a.pop_front();
                check("out_a_pc", bus_a.out_pc, e.pc);
                check("out_a_instr", bus_a.out_instruction, e.instruction);
            end
        end
    end

    initial forever begin
        fetch_packet_type e;
        @(posedge clk);
        #8;
        if (bus_b.out_valid && bus_b.out_ready) begin
            if (sb_b.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL out_b_unexpected actual_pc=%h required=none", bus_b.out_pc);
            end else begin
                e = sb_b.pop_front();
                check("out_b_pc", bus_b.out_pc, e.pc);
                check("out_b_instr", bus_b.out_instruction, e.instruction);
            end
        end
    end

    task automatic push_seq_a(input logic [31:0] base, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) sb_a.push_back(make_pkt(base + 32'(4 * i)));
    endtask

    task automatic push_seq_b(input logic [31:0] base, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) sb_b.push_back(make_pkt(base + 32'(4 * i)));
    endtask

    // consume until the expected queue empties, then stop accepting
    task automatic drain_a(input int unsigned budget);
        int unsigned n = 0;
        while (sb_a.size() != 0 && n < budget) begin
            next_cycle();
            n++;
        end
        bus_a.out_ready = 1'b0;
        check("drain_a_remaining", 32'(sb_a.size()), 32'd0);
        sb_a.delete();
    endtask

    task automatic drain_b(input int unsigned budget);
        int unsigned n = 0;
        while (sb_b.size() != 0 && n < budget) begin
            next_cycle();
            n++;
        end
        bus_b.out_ready = 1'b0;
        check("drain_b_remaining", 32'(sb_b.size()), 32'd0);
        sb_b.delete();
    endtask

    task automatic reset_a(input int unsigned lat);
        next_cycle();
        rst_a = 1'b1;
        bus_a.redirect  = 1'b0;
        bus_a.out_ready = 1'b0;
        lat_a = lat;
        next_cycle();
        next_cycle();
        req_log_a.delete();
        pop_cyc_a.delete();
        sb_a.delete();
        next_cycle();
        rst_a = 1'b0;
        rel_a = cyc;
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.redirect = 1'b0; bus_a.redirect_pc = '0; bus_a.out_ready = 1'b0;
        bus_b.redirect = 1'b0; bus_b.redirect_pc = '0; bus_b.out_ready = 1'b0;
        repeat (3) next_cycle();

        // reset state
        check("rst_req_valid", 32'(bus_a.imem_req_valid), 32'd0);
        check("rst_req_addr", bus_a.imem_req_addr, 32'h0000_0000);
        check("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
        check("rst_out_pc", bus_a.out_pc, 32'd0);
        check("rst_out_instr", bus_a.out_instruction, 32'd0);
        check("rst_b_req_addr", bus_b.imem_req_addr, 32'hFFFF_FFF8);

        // streaming at latency 1: 2-cycle startup then one per cycle
        reset_a(1);
        bus_a.out_ready = 1'b1;
        push_seq_a(32'h0, 8);
        drain_a(40);
        for (int unsigned i = 0; i < 8; i++)
            check($sformatf("t1_pop_cycle_%0d", i), 32'(pop_cyc_a[i]), 32'(rel_a + 2 + i));
        for (int unsigned i = 0; i < 4; i++)
            check($sformatf("t1_req_addr_%0d", i), req_log_a[i], 32'(4 * i));

        // backpressure: credit limits issue to FIFO_DEPTH reads
        reset_a(3);
        repeat (20) next_cycle();
        check("t2_req_count", 32'(req_log_a.size()), 32'd4);
        check("t2_req_valid_held", 32'(bus_a.imem_req_valid), 32'd0);
        check("t2_out_valid_full", 32'(bus_a.out_valid), 32'd1);
        push_seq_a(32'h0, 8);
        bus_a.out_ready = 1'b1;
        drain_a(60);

        // redirect with 3 reads in flight, latency 5
        reset_a(5);
        bus_a.out_ready = 1'b1;
        push_seq_a(32'h100, 6);
        repeat (3) next_cycle();
        check("t3_inflight", 32'(req_log_a.size()), 32'd3);
        bus_a.redirect = 1'b1;
        bus_a.redirect_pc = 32'h0000_0103;
        next_cycle();
        bus_a.redirect = 1'b0;
        drain_a(80);
        check("t3_first_req_after", req_log_a[3], 32'h0000_0100);

        // redirect coinciding with a response, out_ready high
        reset_a(1);
        bus_a.out_ready = 1'b1;
        push_seq_a(32'h0, 2);
        push_seq_a(32'h40, 6);
        repeat (4) next_cycle();
        bus_a.redirect = 1'b1;
        bus_a.redirect_pc = 32'h0000_0040;
        #7;
        check("t4_out_valid_redirect", 32'(bus_a.out_valid), 32'd0);
        next_cycle();
        bus_a.redirect = 1'b0;
        check("t4_pops_before", 32'(pop_cyc_a.size()), 32'd2);
        drain_a(60);
        check("t4_refetch_addr", req_log_a[4], 32'h0000_0040);

        // two redirects two cycles apart, latency 4
        reset_a(4);
        bus_a.out_ready = 1'b1;
        push_seq_a(32'h400, 6);
        repeat (2) next_cycle();
        bus_a.redirect = 1'b1;
        bus_a.redirect_pc = 32'h0000_0200;
        next_cycle();
        bus_a.redirect = 1'b0;
        next_cycle();
        bus_a.redirect = 1'b1;
        bus_a.redirect_pc = 32'h0000_0400;
        next_cycle();
        bus_a.redirect = 1'b0;
        drain_a(80);
        check("t5_req_200", req_log_a[2], 32'h0000_0200);
        check("t5_req_400", req_log_a[3], 32'h0000_0400);

        // PC wrap on the second instance, then mid-stream reset
        next_cycle();
        req_log_b.delete();
        rst_b = 1'b0;
        bus_b.out_ready = 1'b1;
        push_seq_b(32'hFFFF_FFF8, 4);
        drain_b(40);
        check("t6_req0", req_log_b[0], 32'hFFFF_FFF8);
        check("t6_req1", req_log_b[1], 32'hFFFF_FFFC);
        check("t6_req2", req_log_b[2], 32'h0000_0000);
        repeat (3) next_cycle();
        check("t6_valid_before_rst", 32'(bus_b.out_valid), 32'd1);
        rst_b = 1'b1;
        next_cycle();
        rst_b = 1'b0;
        req_log_b.delete();
        check("t6_valid_after_rst", 32'(bus_b.out_valid), 32'd0);
        push_seq_b(32'hFFFF_FFF8, 3);
        bus_b.out_ready = 1'b1;
        drain_b(40);
        check("t6_restart_req0", req_log_b[0], 32'hFFFF_FFF8);
        check("t6_restart_req1", req_log_b[1], 32'hFFFF_FFFC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
